// File: rtl/axi_rd_arb_pkg.sv
// Shared types and constants for the two-requester AXI3 read arbiter.
// Requester ID values are the ones the ICache/DCache put on arid.
package axi_rd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    localparam logic [1:0] AR_LOCK  = 2'b00;
    localparam logic [3:0] AR_CACHE = 4'b0000;
    localparam logic [2:0] AR_PROT  = 3'b000;

    localparam logic [3:0] ID_ICACHE_CACHED   = 4'b0011;
    localparam logic [3:0] ID_ICACHE_UNCACHED = 4'b0010;
    localparam logic [3:0] ID_DCACHE0         = 4'b0100;
    localparam logic [3:0] ID_DCACHE1         = 4'b0101;

endpackage

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester not granted last wins.
// Purely combinational, one-hot (or zero) grant.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_gnt ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI3 read channel between ICache (m0) and DCache (m1): one burst at a
// time, registered AR slice, zero-latency R routing and beat-count checking.
module axi_rd_arbiter
    import axi_rd_arb_pkg::*;
#(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ID_W-1:0]   m0_arid,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic [3:0]        m0_arlen,
    input  logic [2:0]        m0_arsize,
    input  logic [1:0]        m0_arburst,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [ID_W-1:0]   m0_rid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rlast,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    input  logic [ID_W-1:0]   m1_arid,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic [3:0]        m1_arlen,
    input  logic [2:0]        m1_arsize,
    input  logic [1:0]        m1_arburst,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [ID_W-1:0]   m1_rid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rlast,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [ID_W-1:0]   s_arid,
    output logic [ADDR_W-1:0] s_araddr,
    output logic [3:0]        s_arlen,
    output logic [2:0]        s_arsize,
    output logic [1:0]        s_arburst,
    output logic [1:0]        s_arlock,
    output logic [3:0]        s_arcache,
    output logic [2:0]        s_arprot,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [ID_W-1:0]   s_rid,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rlast,
    input  logic              s_rvalid,
    output logic              s_rready,
    output logic              len_err
);

    state_e            state, state_nxt;
    logic [1:0]        req, gnt_oh;
    logic              gnt_q, last_gnt;
    logic              grant_fire, r_beat;
    logic [ID_W-1:0]   ar_id_p1;
    logic [ADDR_W-1:0] ar_addr_p1;
    logic [2:0]        ar_size_p1;
    logic [1:0]        ar_burst_p1;
    logic [3:0]        len_q, beat_cnt;

    assign req        = {m1_arvalid, m0_arvalid};
    assign grant_fire = (state == IDLE) && (req != 2'b00);
    assign r_beat     = (state == DATA) && s_rvalid && s_rready;

    rr_arb2 u_rr_arb2 (
        .req      (req),
        .last_gnt (last_gnt),
        .gnt      (gnt_oh)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req != 2'b00) state_nxt = ADDR;
            ADDR:    if (s_arready) state_nxt = DATA;
            DATA:    if (r_beat && s_rlast) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: arready only for the grantee in IDLE, R routed to gnt_q in DATA.
    always_comb begin
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        m0_rid     = '0;
        m0_rdata   = '0;
        m0_rresp   = '0;
        m0_rlast   = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rid     = '0;
        m1_rdata   = '0;
        m1_rresp   = '0;
        m1_rlast   = 1'b0;
        m1_rvalid  = 1'b0;
        case (state)
            IDLE: begin
                m0_arready = resetn && gnt_oh[0];
                m1_arready = resetn && gnt_oh[1];
            end
            ADDR: s_arvalid = 1'b1;
            DATA: begin
                if (gnt_q) begin
                    m1_rid    = s_rid;
                    m1_rdata  = s_rdata;
                    m1_rresp  = s_rresp;
                    m1_rlast  = s_rlast;
                    m1_rvalid = s_rvalid;
                    s_rready  = m1_rready;
                end else begin
                    m0_rid    = s_rid;
                    m0_rdata  = s_rdata;
                    m0_rresp  = s_rresp;
                    m0_rlast  = s_rlast;
                    m0_rvalid = s_rvalid;
                    s_rready  = m0_rready;
                end
            end
            default: ;
        endcase
    end

    // Stage p1: AR register slice, loaded only on a grant.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            gnt_q       <= 1'b0;
            ar_id_p1    <= '0;
            ar_addr_p1  <= '0;
            len_q       <= '0;
            ar_size_p1  <= '0;
            ar_burst_p1 <= '0;
        end else if (grant_fire) begin
            gnt_q <= gnt_oh[1];
            if (gnt_oh[1]) begin
                ar_id_p1    <= m1_arid;
                ar_addr_p1  <= m1_araddr;
                len_q       <= m1_arlen;
                ar_size_p1  <= m1_arsize;
                ar_burst_p1 <= m1_arburst;
            end else begin
                ar_id_p1    <= m0_arid;
                ar_addr_p1  <= m0_araddr;
                len_q       <= m0_arlen;
                ar_size_p1  <= m0_arsize;
                ar_burst_p1 <= m0_arburst;
            end
        end
    end

    // A short burst (early rlast) and a long one (beat len_q not last) both flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            beat_cnt <= '0;
            last_gnt <= 1'b1;
            len_err  <= 1'b0;
        end else begin
            len_err <= r_beat && (s_rlast ? (beat_cnt != len_q) : (beat_cnt == len_q));
            if (grant_fire) begin
                beat_cnt <= '0;
            end else if (r_beat) begin
                beat_cnt <= beat_cnt + 4'd1;
            end
            if ((state == ADDR) && s_arready) begin
                last_gnt <= gnt_q;
            end
        end
    end

    assign s_arid    = ar_id_p1;
    assign s_araddr  = ar_addr_p1;
    assign s_arlen   = len_q;
    assign s_arsize  = ar_size_p1;
    assign s_arburst = ar_burst_p1;
    assign s_arlock  = AR_LOCK;
    assign s_arcache = AR_CACHE;
    assign s_arprot  = AR_PROT;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: a transaction-level model predicts grant order,
// AR fields, routed R beats and len_err pulses; monitors compare on every DUT output.
module tb_axi_rd_arbiter;
    import axi_rd_arb_pkg::*;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct {
        int               m;
        logic [ID_W-1:0]  id;
        logic [ADDR_W-1:0] addr;
        logic [3:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
    } ar_t;

    typedef struct {
        int              last;
        int              delay;
        logic [ID_W-1:0] id;
        logic [31:0]     seed;
    } plan_t;

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
        logic              err;
    } rexp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [1:0][ID_W-1:0]   arid;
    logic [1:0][ADDR_W-1:0] araddr;
    logic [1:0][3:0]        arlen;
    logic [1:0][2:0]        arsize;
    logic [1:0][1:0]        arburst;
    logic [1:0]             arvalid, arready, rlast, rvalid, rready;
    logic [1:0][ID_W-1:0]   rid;
    logic [1:0][DATA_W-1:0] rdata;
    logic [1:0][1:0]        rresp;
    logic [ID_W-1:0]   s_arid, s_rid;
    logic [ADDR_W-1:0] s_araddr;
    logic [3:0]        s_arlen, s_arcache;
    logic [2:0]        s_arsize, s_arprot;
    logic [1:0]        s_arburst, s_arlock, s_rresp;
    logic              s_arvalid, s_arready, s_rlast, s_rvalid, s_rready, len_err;
    logic [DATA_W-1:0] s_rdata;

    axi_rd_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .resetn(resetn),
        .m0_arid(arid[0]), .m0_araddr(araddr[0]), .m0_arlen(arlen[0]), .m0_arsize(arsize[0]),
        .m0_arburst(arburst[0]), .m0_arvalid(arvalid[0]), .m0_arready(arready[0]),
        .m0_rid(rid[0]), .m0_rdata(rdata[0]), .m0_rresp(rresp[0]), .m0_rlast(rlast[0]),
        .m0_rvalid(rvalid[0]), .m0_rready(rready[0]),
        .m1_arid(arid[1]), .m1_araddr(araddr[1]), .m1_arlen(arlen[1]), .m1_arsize(arsize[1]),
        .m1_arburst(arburst[1]), .m1_arvalid(arvalid[1]), .m1_arready(arready[1]),
        .m1_rid(rid[1]), .m1_rdata(rdata[1]), .m1_rresp(rresp[1]), .m1_rlast(rlast[1]),
        .m1_rvalid(rvalid[1]), .m1_rready(rready[1]),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .len_err(len_err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int model_last = 1;
    int rr_pct = 100;
    bit sl_abort = 1'b1;
    bit sl_busy = 1'b0;
    int rx_cnt [2];

    ar_t   rq0[$], rq1[$], exp_ar[$];
    int    exp_gnt[$];
    plan_t plan_q[$];
    rexp_t er0[$], er1[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit beat_err(int i, int k, int len);
        return (i == k) ? ((i % 16) != len) : ((i % 16) == len);
    endfunction

    // Model one granted burst: expected grant, AR fields, slave plan and routed beats.
    task automatic issue(input int m, input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                         input logic [3:0] len, input int k, input int dly, input logic [31:0] seed);
        ar_t a;
        plan_t p;
        rexp_t e;
        a.m = m; a.id = id; a.addr = addr; a.len = len;
        a.size = 3'($urandom_range(0, 2)); a.burst = 2'($urandom_range(0, 2));
        p.last = k; p.delay = dly; p.id = id; p.seed = seed;
        exp_gnt.push_back(m);
        exp_ar.push_back(a);
        plan_q.push_back(p);
        for (int i = 0; i <= k; i++) begin
            e.id = id; e.data = seed + 32'(i); e.resp = 2'(i);
            e.last = (i == k); e.err = beat_err(i, k, int'(len));
            if (m == 0) er0.push_back(e); else er1.push_back(e);
        end
        if (m == 0) rq0.push_back(a); else rq1.push_back(a);
        model_last = m;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_gnt.size() != 0 || exp_ar.size() != 0 || plan_q.size() != 0 ||
                er0.size() != 0 || er1.size() != 0 || sl_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("round_done", 64'(n < 3000), 64'd1);
        @(negedge clk);
    endtask

    task automatic round(input bit r0, input bit r1, input logic [3:0] l0, input logic [3:0] l1,
                         input int k0, input int k1, input int dly);
        logic [ID_W-1:0] id0, id1;
        id0 = ($urandom_range(0, 1) != 0) ? ID_ICACHE_CACHED : ID_ICACHE_UNCACHED;
        id1 = ($urandom_range(0, 1) != 0) ? ID_DCACHE0 : ID_DCACHE1;
        if (r0 && r1 && model_last == 1) begin
            issue(0, id0, $urandom, l0, k0, dly, $urandom);
            issue(1, id1, $urandom, l1, k1, dly, $urandom);
        end else if (r0 && r1) begin
            issue(1, id1, $urandom, l1, k1, dly, $urandom);
            issue(0, id0, $urandom, l0, k0, dly, $urandom);
        end else if (r0) begin
            issue(0, id0, $urandom, l0, k0, dly, $urandom);
        end else if (r1) begin
            issue(1, id1, $urandom, l1, k1, dly, $urandom);
        end
        wait_done();
    endtask

    // Requesters: present queued AR requests, drop arvalid after the handshake.
    initial begin
        logic [1:0] hs;
        bit act [2];
        ar_t a;
        arvalid = '0; arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; rready = '0;
        act[0] = 1'b0; act[1] = 1'b0;
        forever begin
            @(negedge clk);
            hs = arvalid & arready;
            @(posedge clk);
            #1;
            for (int m = 0; m < 2; m++) begin
                if (sl_abort) begin
                    act[m] = 1'b0;
                    arvalid[m] = 1'b0;
                end else begin
                    if (act[m] && hs[m]) begin
                        act[m] = 1'b0;
                        arvalid[m] = 1'b0;
                    end
                    if (!act[m] && ((m == 0) ? rq0.size() : rq1.size()) != 0) begin
                        a = (m == 0) ? rq0.pop_front() : rq1.pop_front();
                        arid[m] = a.id; araddr[m] = a.addr; arlen[m] = a.len;
                        arsize[m] = a.size; arburst[m] = a.burst;
                        arvalid[m] = 1'b1;
                        act[m] = 1'b1;
                    end
                end
                rready[m] = ($urandom_range(0, 99) < rr_pct);
            end
        end
    end

    // Slave: accepts AR after the planned delay, then returns the planned beats.
    initial begin
        bit ar_hs, r_hs, hold;
        int beat, wcnt;
        plan_t pl;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
        s_rid = '0; s_rdata = '0; s_rresp = '0;
        beat = 0; wcnt = 0;
        forever begin
            @(negedge clk);
            ar_hs = s_arvalid && s_arready;
            r_hs  = s_rvalid && s_rready;
            @(posedge clk);
            #1;
            if (sl_abort) begin
                sl_busy = 1'b0; s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; wcnt = 0;
            end else begin
                if (!sl_busy && ar_hs && plan_q.size() != 0) begin
                    pl = plan_q.pop_front();
                    sl_busy = 1'b1; beat = 0; wcnt = 0; s_arready = 1'b0; r_hs = 1'b0;
                end
                if (sl_busy) begin
                    hold = s_rvalid && !r_hs;
                    if (r_hs) begin
                        if (beat == pl.last) sl_busy = 1'b0;
                        else beat++;
                    end
                    if (!sl_busy) begin
                        s_rvalid = 1'b0;
                        s_rlast  = 1'b0;
                    end else if (!hold) begin
                        s_rvalid = ($urandom_range(0, 3) != 0);
                        s_rid    = pl.id;
                        s_rdata  = pl.seed + 32'(beat);
                        s_rresp  = 2'(beat);
                        s_rlast  = (beat == pl.last);
                    end
                end else if (s_arvalid && plan_q.size() != 0) begin
                    s_arready = (wcnt >= plan_q[0].delay);
                    wcnt++;
                end else begin
                    s_arready = 1'b0;
                end
            end
        end
    end

    // Monitor: compares every DUT output event against the model queues.
    initial begin
        bit pend_err, sv_exp, in_data, got;
        int cur_m, g, o;
        rexp_t e;
        ar_t a;
        pend_err = 1'b0; sv_exp = 1'b0; in_data = 1'b0; cur_m = 0;
        rx_cnt[0] = 0; rx_cnt[1] = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                pend_err = 1'b0; sv_exp = 1'b0; in_data = 1'b0;
            end else begin
                chk("len_err", 64'(len_err), 64'(pend_err));
                pend_err = 1'b0;
                if (sv_exp) chk("s_arvalid_latency", 64'(s_arvalid), 64'd1);
                sv_exp = (arready != 2'b00);
                if (arready != 2'b00) begin
                    if (exp_gnt.size() == 0) begin
                        chk("arready_unexpected", 64'(arready), 64'd0);
                    end else begin
                        g = exp_gnt.pop_front();
                        chk("grant", 64'(arready), 64'(2'b01 << g));
                    end
                end
                for (int m = 0; m < 2; m++) begin
                    if (rvalid[m] && rready[m]) begin
                        got = 1'b0;
                        if (m == 0 && er0.size() != 0) begin e = er0.pop_front(); got = 1'b1; end
                        if (m == 1 && er1.size() != 0) begin e = er1.pop_front(); got = 1'b1; end
                        if (!got) begin
                            chk("rbeat_unexpected", 64'(rvalid[m]), 64'd0);
                        end else begin
                            chk("rdata", 64'(rdata[m]), 64'(e.data));
                            chk("rid", 64'(rid[m]), 64'(e.id));
                            chk("rresp", 64'(rresp[m]), 64'(e.resp));
                            chk("rlast", 64'(rlast[m]), 64'(e.last));
                            pend_err = e.err;
                            rx_cnt[m]++;
                            if (e.last) in_data = 1'b0;
                        end
                    end
                end
                if (in_data) begin
                    o = 1 - cur_m;
                    chk("idle_side_zero", 64'({rid[o], rdata[o], rresp[o], rlast[o], rvalid[o]}), 64'd0);
                    chk("rvalid_route", 64'(rvalid[cur_m]), 64'(s_rvalid));
                    if (s_rvalid) chk("s_rready_follow", 64'(s_rready), 64'(rready[cur_m]));
                end
                if (s_arvalid) begin
                    if (exp_ar.size() == 0) begin
                        chk("s_arvalid_unexpected", 64'(s_arvalid), 64'd0);
                    end else begin
                        a = exp_ar[0];
                        chk("s_araddr", 64'(s_araddr), 64'(a.addr));
                        chk("s_arid", 64'(s_arid), 64'(a.id));
                        chk("s_arlen", 64'(s_arlen), 64'(a.len));
                        chk("s_arsize_burst", 64'({s_arsize, s_arburst}), 64'({a.size, a.burst}));
                        chk("s_ar_tieoffs", 64'({s_arlock, s_arcache, s_arprot}), 64'd0);
                        if (s_arready) begin
                            void'(exp_ar.pop_front());
                            cur_m = a.m;
                            in_data = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic idle_checks(input string tag);
        chk({tag, "_s_arvalid"}, 64'(s_arvalid), 64'd0);
        chk({tag, "_rvalid"}, 64'(rvalid), 64'd0);
        chk({tag, "_arready"}, 64'(arready), 64'd0);
        chk({tag, "_s_rready"}, 64'(s_rready), 64'd0);
        chk({tag, "_len_err"}, 64'(len_err), 64'd0);
        chk({tag, "_ar_regs"}, 64'({s_araddr, s_arid, s_arlen}), 64'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: run still active at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(negedge clk);
        idle_checks("reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;
        sl_abort = 1'b0;
        @(negedge clk);

        // Tie after reset: m0 first, m1 next; then a second tie goes to m0 again.
        round(1'b1, 1'b1, 4'd0, 4'd3, 0, 3, 0);
        round(1'b1, 1'b1, 4'd1, 4'd2, 1, 2, 1);

        issue(0, ID_ICACHE_CACHED, 32'h1FC0_0040, 4'hF, 15, 0, 32'h0000_1000);
        wait_done();

        // AR backpressure while m0 already presents its next, different request.
        issue(0, ID_ICACHE_CACHED, 32'h1FC0_0080, 4'd2, 2, 5, $urandom);
        issue(0, ID_ICACHE_UNCACHED, 32'hBFC0_0000, 4'd1, 1, 0, $urandom);
        wait_done();

        rr_pct = 40;
        issue(1, ID_DCACHE0, 32'h8000_0100, 4'd3, 3, 0, 32'h0000_00A0);
        wait_done();
        rr_pct = 100;

        // Short burst, then a burst whose rlast comes one beat late.
        issue(0, ID_ICACHE_CACHED, 32'h1FC0_0100, 4'd3, 2, 0, $urandom);
        wait_done();
        issue(1, ID_DCACHE1, 32'h8000_0200, 4'd3, 4, 0, $urandom);
        wait_done();

        for (int r = 0; r < 40; r++) begin
            int sel, k0, k1;
            logic [3:0] l0, l1;
            sel = $urandom_range(0, 2);
            l0 = 4'($urandom_range(0, 15));
            l1 = 4'($urandom_range(0, 15));
            k0 = ($urandom_range(0, 6) == 0) ? $urandom_range(0, int'(l0) + 2) : int'(l0);
            k1 = ($urandom_range(0, 6) == 0) ? $urandom_range(0, int'(l1) + 2) : int'(l1);
            rr_pct = $urandom_range(40, 100);
            round(sel != 1, sel != 0, l0, l1, k0, k1, $urandom_range(0, 3));
        end
        rr_pct = 100;

        // Reset in the middle of a 16-beat m0 burst.
        base = rx_cnt[0];
        issue(0, ID_ICACHE_CACHED, 32'h1FC0_0400, 4'hF, 15, 0, $urandom);
        n = 0;
        while (rx_cnt[0] < base + 5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("midburst_reached", 64'(rx_cnt[0] >= base + 5), 64'd1);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        sl_abort = 1'b1;
        exp_gnt.delete(); exp_ar.delete(); plan_q.delete();
        er0.delete(); er1.delete(); rq0.delete(); rq1.delete();
        model_last = 1;
        @(posedge clk);
        @(negedge clk);
        idle_checks("midreset");
        @(posedge clk);
        #1;
        resetn = 1'b1;
        sl_abort = 1'b0;
        @(negedge clk);
        round(1'b0, 1'b1, 4'd0, 4'd2, 0, 2, 0);
        round(1'b1, 1'b1, 4'd1, 4'd1, 1, 1, 0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
